// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: write-back has zero-latency priority, auxiliary
// results queue in a small FIFO and drain into idle port cycles, with scoreboard and stall.
module wb_write_arbiter #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_en_in,
  input  logic [4:0]  wb_addr_in,
  input  logic [31:0] wb_data_in,
  input  logic        aux_valid,
  output logic        aux_ready,
  input  logic [4:0]  aux_addr,
  input  logic [31:0] aux_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stall_req,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic        rs_pending,
  output logic        rt_pending
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = 4;

  typedef struct packed {
    logic        live;
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  entry_t          fifo_q [DEPTH];
  logic [AW-1:0]   head_q;
  logic [AW-1:0]   tail_q;
  logic [CW-1:0]   count_q;
  logic [WW-1:0]   wait_q;
  logic [WW-1:0]   wait_d;
  logic            wb_hit;
  logic            pop;
  logic            push;
  logic            push_wr;

  assign aux_ready = (count_q < CW'(DEPTH));
  assign wb_hit    = wb_en_in && (wb_addr_in != 5'd0);
  assign pop       = !wb_hit && (count_q != '0);
  assign push      = aux_valid && aux_ready;
  // Results for r0 are acknowledged but never occupy a slot.
  assign push_wr   = push && (aux_addr != 5'd0);

  // Port mux: write-back first, then FIFO head (possibly a superseded bubble).
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (!reset) begin
      if (wb_hit) begin
        rf_we    = 1'b1;
        rf_waddr = wb_addr_in;
        rf_wdata = wb_data_in;
      end else if (pop) begin
        rf_we    = fifo_q[head_q].live;
        rf_waddr = fifo_q[head_q].addr;
        rf_wdata = fifo_q[head_q].data;
      end
    end
  end

  // Scoreboard over live entries only.
  always_comb begin
    rs_pending = 1'b0;
    rt_pending = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (fifo_q[AW'(i)].live && (fifo_q[AW'(i)].addr == rs_addr)) rs_pending = 1'b1;
      if (fifo_q[AW'(i)].live && (fifo_q[AW'(i)].addr == rt_addr)) rt_pending = 1'b1;
    end
    if (rs_addr == 5'd0) rs_pending = 1'b0;
    if (rt_addr == 5'd0) rt_pending = 1'b0;
  end

  // Saturating starvation counter.
  always_comb begin
    wait_d = wait_q;
    if (pop || (count_q == '0)) begin
      wait_d = '0;
    end else if (wait_q != '1) begin
      wait_d = wait_q + WW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_q[AW'(i)] <= '0;
      end
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wait_q    <= '0;
      stall_req <= 1'b0;
    end else begin
      // A write-back is younger than everything queued; kill matching entries.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wb_hit && fifo_q[AW'(i)].live && (fifo_q[AW'(i)].addr == wb_addr_in)) begin
          fifo_q[AW'(i)].live <= 1'b0;
        end
      end
      if (pop) begin
        fifo_q[head_q].live <= 1'b0;
        head_q              <= head_q + AW'(1);
      end
      if (push_wr) begin
        fifo_q[tail_q] <= '{live: 1'b1, addr: aux_addr, data: aux_data};
        tail_q         <= tail_q + AW'(1);
      end
      count_q <= count_q + CW'(push_wr) - CW'(pop);
      wait_q  <= wait_d;
      if (pop) begin
        stall_req <= 1'b0;
      end else if (wait_d == WW'(MAX_WAIT)) begin
        stall_req <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter (DEPTH=2, MAX_WAIT=4): inputs driven after the
// falling edge, outputs checked 1ns later, register writes captured on the rising edge.
module tb_wb_write_arbiter;

  logic        clk;
  logic        reset;
  logic        wb_en_in;
  logic [4:0]  wb_addr_in;
  logic [31:0] wb_data_in;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_addr;
  logic [31:0] aux_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        rs_pending;
  logic        rt_pending;

  int vec_cnt;
  int err_cnt;
  int wr_cnt;
  logic [31:0] regs [32];

  wb_write_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .wb_en_in(wb_en_in), .wb_addr_in(wb_addr_in), .wb_data_in(wb_data_in),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_addr(aux_addr), .aux_data(aux_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall_req(stall_req),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_pending(rs_pending), .rt_pending(rt_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural register file as seen through the write port.
  always @(posedge clk) begin
    if (rf_we) begin
      regs[rf_waddr] <= rf_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic test_reset();
    wb_en_in = 1'b1; wb_addr_in = 5'd5; wb_data_in = 32'h1234;
    #1;
    vec_cnt++; if (rf_we !== 1'b0) begin err_cnt++; $display("FAIL reset_rf_we got=%0b exp=0", rf_we); end
    vec_cnt++; if (aux_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_aux_ready got=%0b exp=1", aux_ready); end
    vec_cnt++; if (stall_req !== 1'b0) begin err_cnt++; $display("FAIL reset_stall got=%0b exp=0", stall_req); end
    vec_cnt++; if (rs_pending !== 1'b0) begin err_cnt++; $display("FAIL reset_rs_pending got=%0b exp=0", rs_pending); end
    @(negedge clk);
    wb_en_in = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_wb_only();
    @(negedge clk);
    wb_en_in = 1'b1; wb_addr_in = 5'd5; wb_data_in = 32'h1234;
    #1;
    vec_cnt++; if (rf_we !== 1'b1) begin err_cnt++; $display("FAIL wb_we got=%0b exp=1", rf_we); end
    vec_cnt++; if (rf_waddr !== 5'd5) begin err_cnt++; $display("FAIL wb_addr got=%0d exp=5", rf_waddr); end
    vec_cnt++; if (rf_wdata !== 32'h1234) begin err_cnt++; $display("FAIL wb_data got=%h exp=00001234", rf_wdata); end
    @(negedge clk);
    wb_addr_in = 5'd0; wb_data_in = 32'hDEAD;
    #1;
    vec_cnt++; if (rf_we !== 1'b0) begin err_cnt++; $display("FAIL wb_r0_we got=%0b exp=0", rf_we); end
    @(negedge clk);
    wb_en_in = 1'b0;
  endtask

  task automatic test_aux_drain();
    @(negedge clk);
    aux_valid = 1'b1; aux_addr = 5'd8; aux_data = 32'hAA; rs_addr = 5'd8;
    #1;
    vec_cnt++; if (rf_we !== 1'b0) begin err_cnt++; $display("FAIL aux_no_bypass got=%0b exp=0", rf_we); end
    vec_cnt++; if (rs_pending !== 1'b0) begin err_cnt++; $display("FAIL aux_pend_incoming got=%0b exp=0", rs_pending); end
    @(negedge clk);
    aux_valid = 1'b0;
    #1;
    vec_cnt++; if (rf_we !== 1'b1) begin err_cnt++; $display("FAIL aux_we got=%0b exp=1", rf_we); end
    vec_cnt++; if (rf_waddr !== 5'd8) begin err_cnt++; $display("FAIL aux_addr got=%0d exp=8", rf_waddr); end
    vec_cnt++; if (rf_wdata !== 32'hAA) begin err_cnt++; $display("FAIL aux_data got=%h exp=000000aa", rf_wdata); end
    vec_cnt++; if (rs_pending !== 1'b1) begin err_cnt++; $display("FAIL aux_pend_live got=%0b exp=1", rs_pending); end
    @(negedge clk);
    #1;
    vec_cnt++; if (rs_pending !== 1'b0) begin err_cnt++; $display("FAIL aux_pend_after got=%0b exp=0", rs_pending); end
    vec_cnt++; if (rf_we !== 1'b0) begin err_cnt++; $display("FAIL aux_idle_we got=%0b exp=0", rf_we); end
  endtask

  task automatic test_full();
    @(negedge clk);
    wb_en_in = 1'b1; wb_addr_in = 5'd1; wb_data_in = 32'h100;
    aux_valid = 1'b1; aux_addr = 5'd10; aux_data = 32'hA0;
    #1;
    vec_cnt++; if (aux_ready !== 1'b1) begin err_cnt++; $display("FAIL full_rdy0 got=%0b exp=1", aux_ready); end
    @(negedge clk);
    aux_addr = 5'd11; aux_data = 32'hB0;
    #1;
    vec_cnt++; if (aux_ready !== 1'b1) begin err_cnt++; $display("FAIL full_rdy1 got=%0b exp=1", aux_ready); end
    vec_cnt++; if (rf_waddr !== 5'd1) begin err_cnt++; $display("FAIL full_wb_prio got=%0d exp=1", rf_waddr); end
    @(negedge clk);
    aux_addr = 5'd12; aux_data = 32'hC0;
    #1;
    vec_cnt++; if (aux_ready !== 1'b0) begin err_cnt++; $display("FAIL full_rdy2 got=%0b exp=0", aux_ready); end
    @(negedge clk);
    wb_en_in = 1'b0; aux_valid = 1'b0;
    #1;
    vec_cnt++; if (aux_ready !== 1'b0) begin err_cnt++; $display("FAIL full_rdy_prepop got=%0b exp=0", aux_ready); end
    vec_cnt++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd10, 32'hA0}) begin
      err_cnt++; $display("FAIL full_drain0 got=%0b/%0d/%h exp=1/10/000000a0", rf_we, rf_waddr, rf_wdata); end
    @(negedge clk);
    #1;
    vec_cnt++; if (aux_ready !== 1'b1) begin err_cnt++; $display("FAIL full_rdy_back got=%0b exp=1", aux_ready); end
    vec_cnt++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd11, 32'hB0}) begin
      err_cnt++; $display("FAIL full_drain1 got=%0b/%0d/%h exp=1/11/000000b0", rf_we, rf_waddr, rf_wdata); end
    @(negedge clk);
    #1;
    vec_cnt++; if (rf_we !== 1'b0) begin err_cnt++; $display("FAIL full_no_third got=%0b exp=0", rf_we); end
  endtask

  task automatic test_supersede();
    @(negedge clk);
    aux_valid = 1'b1; aux_addr = 5'd9; aux_data = 32'h11; rt_addr = 5'd9;
    @(negedge clk);
    aux_valid = 1'b0;
    wb_en_in = 1'b1; wb_addr_in = 5'd9; wb_data_in = 32'h22;
    #1;
    vec_cnt++; if (rt_pending !== 1'b1) begin err_cnt++; $display("FAIL sup_pend_before got=%0b exp=1", rt_pending); end
    vec_cnt++; if (rf_wdata !== 32'h22) begin err_cnt++; $display("FAIL sup_wb_data got=%h exp=00000022", rf_wdata); end
    @(negedge clk);
    wb_en_in = 1'b0;
    #1;
    vec_cnt++; if (rt_pending !== 1'b0) begin err_cnt++; $display("FAIL sup_pend_after got=%0b exp=0", rt_pending); end
    vec_cnt++; if (rf_we !== 1'b0) begin err_cnt++; $display("FAIL sup_bubble_we got=%0b exp=0", rf_we); end
    @(negedge clk);
    #1;
    vec_cnt++; if (regs[9] !== 32'h22) begin err_cnt++; $display("FAIL sup_r9 got=%h exp=00000022", regs[9]); end
  endtask

  task automatic test_starvation();
    @(negedge clk);
    wb_en_in = 1'b1; wb_addr_in = 5'd2; wb_data_in = 32'h2;
    aux_valid = 1'b1; aux_addr = 5'd7; aux_data = 32'h77;
    @(negedge clk);
    aux_valid = 1'b0;
    #1;
    vec_cnt++; if (stall_req !== 1'b0) begin err_cnt++; $display("FAIL starve_c0 got=%0b exp=0", stall_req); end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      #1;
      vec_cnt++;
      if (stall_req !== (i >= 4)) begin
        err_cnt++; $display("FAIL starve_c%0d got=%0b exp=%0b", i, stall_req, (i >= 4));
      end
    end
    wb_en_in = 1'b0;
    #1;
    vec_cnt++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'h77}) begin
      err_cnt++; $display("FAIL starve_drain got=%0b/%0d/%h exp=1/7/00000077", rf_we, rf_waddr, rf_wdata); end
    vec_cnt++; if (stall_req !== 1'b1) begin err_cnt++; $display("FAIL starve_hold got=%0b exp=1", stall_req); end
    @(negedge clk);
    #1;
    vec_cnt++; if (stall_req !== 1'b0) begin err_cnt++; $display("FAIL starve_release got=%0b exp=0", stall_req); end
  endtask

  task automatic test_async_reset();
    int wr_snap;
    @(negedge clk);
    wb_en_in = 1'b1; wb_addr_in = 5'd3; wb_data_in = 32'h3;
    aux_valid = 1'b1; aux_addr = 5'd4; aux_data = 32'h44; rs_addr = 5'd4;
    @(negedge clk);
    aux_addr = 5'd6; aux_data = 32'h66;
    @(negedge clk);
    aux_valid = 1'b0; wb_en_in = 1'b0;
    #1;
    vec_cnt++; if (rs_pending !== 1'b1) begin err_cnt++; $display("FAIL arst_pend_pre got=%0b exp=1", rs_pending); end
    vec_cnt++; if (rf_we !== 1'b1) begin err_cnt++; $display("FAIL arst_we_pre got=%0b exp=1", rf_we); end
    reset = 1'b1;
    #1;
    vec_cnt++; if (rf_we !== 1'b0) begin err_cnt++; $display("FAIL arst_we got=%0b exp=0", rf_we); end
    vec_cnt++; if (aux_ready !== 1'b1) begin err_cnt++; $display("FAIL arst_rdy got=%0b exp=1", aux_ready); end
    vec_cnt++; if (stall_req !== 1'b0) begin err_cnt++; $display("FAIL arst_stall got=%0b exp=0", stall_req); end
    vec_cnt++; if (rs_pending !== 1'b0) begin err_cnt++; $display("FAIL arst_pend got=%0b exp=0", rs_pending); end
    wr_snap = wr_cnt;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vec_cnt++; if (wr_cnt !== wr_snap) begin err_cnt++; $display("FAIL arst_no_writes got=%0d exp=%0d", wr_cnt, wr_snap); end
  endtask

  initial begin
    vec_cnt = 0; err_cnt = 0; wr_cnt = 0;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    reset = 1'b1;
    wb_en_in = 1'b0; wb_addr_in = 5'd0; wb_data_in = 32'd0;
    aux_valid = 1'b0; aux_addr = 5'd0; aux_data = 32'd0;
    rs_addr = 5'd0; rt_addr = 5'd0;
    @(negedge clk);
    test_reset();
    test_wb_only();
    test_aux_drain();
    test_full();
    test_supersede();
    test_starvation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
